instr_queue: RTL and testbench

Parametrised instruction holding buffer for the mips_cpu core. It is the successor to the single-entry instruction register. It stores up to DEPTH fetched instruction words, each with its PC, in a circular FIFO. The head entry is presented as fully decoded R/I/J fields with a format tag. It sits between the fetch/memory interface and the control unit, with valid/ready handshakes on both sides and a flush input for taken branches and jumps.

---
 rtl/instr_queue_pkg.sv | 21 ++
 rtl/instr_queue_fields.sv | 54 +++++
 rtl/instr_queue.sv | 111 +++++++++++
 tb/tb_instr_queue.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_queue_pkg.sv
// Shared MIPS instruction types and the head-format tag used by the
// instruction queue and later decode stages.
package codes;

  typedef logic [31:0] size_t;
  typedef logic [5:0]  opcode_t;
  typedef logic [5:0]  funct_t;
  typedef logic [4:0]  regaddr_t;

  localparam opcode_t OP_SPECIAL = 6'h00;
  localparam opcode_t OP_J       = 6'h02;
  localparam opcode_t OP_JAL     = 6'h03;

  typedef enum logic [1:0] {
    FMT_NONE = 2'd0,
    FMT_R    = 2'd1,
    FMT_I    = 2'd2,
    FMT_J    = 2'd3
  } instr_fmt_t;

endpackage

// File: rtl/instr_queue_fields.sv
// Combinational instruction word splitter: R/I/J field extraction plus a
// format tag; every field is zero when the word is not valid.
module instr_fields
  import codes::*;
(
  input  logic       valid,
  input  size_t      instr,
  output instr_fmt_t fmt,
  output opcode_t    opcode,
  output regaddr_t   rs,
  output regaddr_t   rt,
  output regaddr_t   rd,
  output logic [4:0] shift,
  output funct_t     funct,
  output logic [15:0] immediate,
  output logic [25:0] target
);

  always_comb begin
    fmt       = FMT_NONE;
    opcode    = '0;
    rs        = '0;
    rt        = '0;
    rd        = '0;
    shift     = '0;
    funct     = '0;
    immediate = '0;
    target    = '0;
    if (valid) begin
      opcode = instr[31:26];
      case (instr[31:26])
        OP_SPECIAL: begin
          fmt   = FMT_R;
          rs    = instr[25:21];
          rt    = instr[20:16];
          rd    = instr[15:11];
          shift = instr[10:6];
          funct = instr[5:0];
        end
        OP_J, OP_JAL: begin
          fmt    = FMT_J;
          target = instr[25:0];
        end
        default: begin
          fmt       = FMT_I;
          rs        = instr[25:21];
          rt        = instr[20:16];
          immediate = instr[15:0];
        end
      endcase
    end
  end

endmodule

// File: rtl/instr_queue.sv
// Circular instruction FIFO between fetch and control, with optional
// empty-queue bypass, flush for taken branches, and a decoded head view.
module instr_queue
  import codes::*;
#(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32,
  parameter int BYPASS = 1
) (
  input  logic                   clk,
  input  logic                   reset_n_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  size_t                  instr_i,
  input  logic [PC_W-1:0]        pc_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  input  logic                   flush_i,
  output logic [PC_W-1:0]        pc_o,
  output size_t                  instr_o,
  output instr_fmt_t             fmt_o,
  output opcode_t                opcode_o,
  output regaddr_t               rs_o,
  output regaddr_t               rt_o,
  output regaddr_t               rd_o,
  output logic [4:0]             shift_o,
  output funct_t                 funct_o,
  output logic [15:0]            immediate_o,
  output logic [25:0]            target_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam bit BYP = (BYPASS != 0);

  size_t           mem    [DEPTH];
  logic [PC_W-1:0] pc_mem [DEPTH];

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          empty, full, bypass_sel;
  logic          push_acc, pop, pass_through, do_write, do_read;
  size_t         head_instr;
  logic [PC_W-1:0] head_pc;

  assign empty      = (count == '0);
  assign full       = (count == CW'(DEPTH));
  assign in_ready_o = !full;
  assign bypass_sel = BYP && empty;

  // Reset is folded in so a bypassed input cannot leak out while held in reset.
  assign out_valid_o = reset_n_i && !flush_i && (!empty || (BYP && in_valid_i));

  assign push_acc = in_valid_i && in_ready_o && !flush_i;
  assign pop      = out_valid_o && out_ready_i;

  // A bypassed word consumed in the same cycle never touches storage.
  assign pass_through = bypass_sel && pop;
  assign do_write     = push_acc && !pass_through;
  assign do_read      = pop && !pass_through;

  assign head_instr = bypass_sel ? instr_i : mem[rd_ptr];
  assign head_pc    = bypass_sel ? pc_i    : pc_mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (do_read)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_write, do_read})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr]    <= instr_i;
      pc_mem[wr_ptr] <= pc_i;
    end
  end

  assign count_o = count;
  assign instr_o = out_valid_o ? head_instr : '0;
  assign pc_o    = out_valid_o ? head_pc    : '0;

  instr_fields u_fields (
    .valid     (out_valid_o),
    .instr     (head_instr),
    .fmt       (fmt_o),
    .opcode    (opcode_o),
    .rs        (rs_o),
    .rt        (rt_o),
    .rd        (rd_o),
    .shift     (shift_o),
    .funct     (funct_o),
    .immediate (immediate_o),
    .target    (target_o)
  );

endmodule

// File: tb/tb_instr_queue.sv
// Scoreboard bench for instr_queue: a non-bypass instance for FIFO, wrap,
// flush and reset behaviour, and a bypass instance for pass-through.
module tb_instr_queue;
  import codes::*;

  typedef struct {
    logic [31:0] w;
    logic [31:0] pc;
    logic [1:0]  fmt;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [25:0] tgt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // non-bypass instance
  logic        in_valid, out_ready, flush;
  logic [31:0] instr, pc;
  logic        in_ready, out_valid;
  logic [31:0] pc_o, instr_o;
  instr_fmt_t  fmt_o;
  logic [5:0]  opcode_o, funct_o;
  logic [4:0]  rs_o, rt_o, rd_o, shift_o;
  logic [15:0] imm_o;
  logic [25:0] tgt_o;
  logic [2:0]  count_o;

  // bypass instance
  logic        b_in_valid, b_out_ready, b_flush;
  logic [31:0] b_instr, b_pc;
  logic        b_in_ready, b_out_valid;
  logic [31:0] b_pc_o, b_instr_o;
  instr_fmt_t  b_fmt_o;
  logic [5:0]  b_opcode_o, b_funct_o;
  logic [4:0]  b_rs_o, b_rt_o, b_rd_o, b_shift_o;
  logic [15:0] b_imm_o;
  logic [25:0] b_tgt_o;
  logic [2:0]  b_count_o;

  instr_queue #(.DEPTH(4), .PC_W(32), .BYPASS(0)) dut (
    .clk(clk), .reset_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .instr_i(instr), .pc_i(pc), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .flush_i(flush), .pc_o(pc_o), .instr_o(instr_o), .fmt_o(fmt_o),
    .opcode_o(opcode_o), .rs_o(rs_o), .rt_o(rt_o), .rd_o(rd_o), .shift_o(shift_o),
    .funct_o(funct_o), .immediate_o(imm_o), .target_o(tgt_o), .count_o(count_o)
  );

  instr_queue #(.DEPTH(4), .PC_W(32), .BYPASS(1)) dut_byp (
    .clk(clk), .reset_n_i(rst_n), .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
    .instr_i(b_instr), .pc_i(b_pc), .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
    .flush_i(b_flush), .pc_o(b_pc_o), .instr_o(b_instr_o), .fmt_o(b_fmt_o),
    .opcode_o(b_opcode_o), .rs_o(b_rs_o), .rt_o(b_rt_o), .rd_o(b_rd_o), .shift_o(b_shift_o),
    .funct_o(b_funct_o), .immediate_o(b_imm_o), .target_o(b_tgt_o), .count_o(b_count_o)
  );

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] w, input logic [31:0] p, input logic [1:0] f,
                              input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                              input logic [15:0] imm, input logic [25:0] tgt);
    exp_t e;
    e.w = w; e.pc = p; e.fmt = f; e.op = op; e.rs = rs; e.rt = rt; e.rd = rd;
    e.sh = sh; e.fn = fn; e.imm = imm; e.tgt = tgt;
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_w(input logic [31:0] w, input logic [31:0] p);
    in_valid = 1'b1;
    instr    = w;
    pc       = p;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_count"},     32'(count_o),   0);
    chk({tag, "_fmt"},       32'(fmt_o),     32'(FMT_NONE));
    chk({tag, "_rs"},        32'(rs_o),      0);
    chk({tag, "_imm"},       32'(imm_o),     0);
    chk({tag, "_tgt"},       32'(tgt_o),     0);
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; instr = '0; pc = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_flush = 1'b0; b_instr = '0; b_pc = '0;

    fork
      forever begin
        @(negedge clk);
        if (rst_n && out_valid && out_ready) begin
          if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_output: got instr 0x%0h, expected no output", instr_o);
          end else begin
            e = sb.pop_front();
            chk("sb_instr", instr_o,          e.w);
            chk("sb_pc",    pc_o,             e.pc);
            chk("sb_fmt",   32'(fmt_o),       32'(e.fmt));
            chk("sb_op",    32'(opcode_o),    32'(e.op));
            chk("sb_rs",    32'(rs_o),        32'(e.rs));
            chk("sb_rt",    32'(rt_o),        32'(e.rt));
            chk("sb_rd",    32'(rd_o),        32'(e.rd));
            chk("sb_shift", 32'(shift_o),     32'(e.sh));
            chk("sb_funct", 32'(funct_o),     32'(e.fn));
            chk("sb_imm",   32'(imm_o),       32'(e.imm));
            chk("sb_tgt",   32'(tgt_o),       32'(e.tgt));
          end
        end
      end
    join_none

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle("rst");
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_b_in_ready", 32'(b_in_ready), 1);
    chk("rst_b_out_valid", 32'(b_out_valid), 0);
    tick();
    rst_n = 1'b1;

    // single R-type push, one-cycle latency
    sb.push_back(mk(32'h012A4020, 32'h0, 2'd1, 6'h00, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 16'h0, 26'h0));
    push_w(32'h012A4020, 32'h0);
    @(negedge clk);
    chk("t1_out_valid", 32'(out_valid), 1);
    chk("t1_count", 32'(count_o), 1);
    chk("t1_fmt", 32'(fmt_o), 32'(FMT_R));
    chk("t1_rd", 32'(rd_o), 8);
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // fill to DEPTH, reject fifth push, then drain in order
    sb.push_back(mk(32'h2128FFFF, 32'h100, 2'd2, 6'h08, 5'd9, 5'd8, 5'd0, 5'd0, 6'h0, 16'hFFFF, 26'h0));
    sb.push_back(mk(32'h08000010, 32'h104, 2'd3, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h10));
    sb.push_back(mk(32'h0C000004, 32'h108, 2'd3, 6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h4));
    sb.push_back(mk(32'h00000000, 32'h10C, 2'd1, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0));
    push_w(32'h2128FFFF, 32'h100);
    push_w(32'h08000010, 32'h104);
    push_w(32'h0C000004, 32'h108);
    push_w(32'h00000000, 32'h10C);
    @(negedge clk);
    chk("full_count", 32'(count_o), 4);
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_fmt", 32'(fmt_o), 32'(FMT_I));
    chk("full_rs", 32'(rs_o), 9);
    chk("full_rt", 32'(rt_o), 8);
    chk("full_imm", 32'(imm_o), 32'hFFFF);
    push_w(32'h3C011234, 32'h110);
    @(negedge clk);
    chk("over_count", 32'(count_o), 4);
    chk("over_head_stable", instr_o, 32'h2128FFFF);
    tick();
    out_ready = 1'b1;
    repeat (4) tick();
    out_ready = 1'b0;
    @(negedge clk);
    chk("drain_count", 32'(count_o), 0);
    chk("drain_out_valid", 32'(out_valid), 0);

    // continuous push/pop at occupancy 1 across two pointer wraps
    sb.push_back(mk(32'h21280000, 32'h200, 2'd2, 6'h08, 5'd9, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0));
    push_w(32'h21280000, 32'h200);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      instr = 32'h21280000 | 32'(k);
      pc    = 32'h200 + 32'(4 * k);
      sb.push_back(mk(instr, pc, 2'd2, 6'h08, 5'd9, 5'd8, 5'd0, 5'd0, 6'h0, 16'(k), 26'h0));
      @(negedge clk);
      chk("wrap_count", 32'(count_o), 1);
      tick();
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    chk("wrap_end_count", 32'(count_o), 0);

    // bypass instance: pass-through when consumed, written when not
    tick();
    b_in_valid  = 1'b1;
    b_instr     = 32'h2128FFFF;
    b_pc        = 32'h300;
    b_out_ready = 1'b1;
    @(negedge clk);
    chk("byp_out_valid", 32'(b_out_valid), 1);
    chk("byp_imm", 32'(b_imm_o), 32'hFFFF);
    chk("byp_fmt", 32'(b_fmt_o), 32'(FMT_I));
    chk("byp_pc", b_pc_o, 32'h300);
    tick();
    b_in_valid  = 1'b0;
    b_out_ready = 1'b0;
    @(negedge clk);
    chk("byp_count_after", 32'(b_count_o), 0);
    chk("byp_idle_valid", 32'(b_out_valid), 0);
    tick();
    b_in_valid = 1'b1;
    b_instr    = 32'h08000010;
    b_pc       = 32'h304;
    tick();
    b_in_valid = 1'b0;
    @(negedge clk);
    chk("byp_held_count", 32'(b_count_o), 1);
    chk("byp_held_tgt", 32'(b_tgt_o), 32'h10);
    tick();
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    @(negedge clk);
    chk("byp_drain_count", 32'(b_count_o), 0);

    // flush at count 3 with a simultaneous push and ready
    tick();
    push_w(32'h3C011234, 32'h400);
    push_w(32'h3C011235, 32'h404);
    push_w(32'h3C011236, 32'h408);
    flush     = 1'b1;
    in_valid  = 1'b1;
    instr     = 32'h3C01BEEF;
    out_ready = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", 32'(out_valid), 0);
    chk("flush_in_ready", 32'(in_ready), 1);
    chk("flush_fmt", 32'(fmt_o), 32'(FMT_NONE));
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk_idle("post_flush");
    repeat (2) tick();
    out_ready = 1'b0;

    // asynchronous reset mid-cycle at count 2
    push_w(32'h3C011234, 32'h500);
    push_w(32'h3C011235, 32'h504);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    tick();
    rst_n = 1'b1;
    sb.push_back(mk(32'h08000010, 32'h600, 2'd3, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h10));
    push_w(32'h08000010, 32'h600);
    @(negedge clk);
    chk("post_rst_count", 32'(count_o), 1);
    chk("post_rst_tgt", 32'(tgt_o), 32'h10);
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    repeat (2) tick();
    chk("sb_leftover", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
